// File: rtl/dma_csr_regfile_pkg.sv
// -----------------------------------------------------------------------------
// dma_csr_pkg
// Shared definitions for the DMA CSR register file: the bus FSM state type,
// the per-channel register offsets and the CTRL/STATUS bit positions.
// Used by dma_csr_channel and dma_csr_regfile.
// -----------------------------------------------------------------------------
package dma_csr_pkg;

  // Bus-side FSM states of the CSR slave
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_EN    = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RD_VALID = 2'd3
  } csr_state_e;

  // Register offsets within one channel (csr_addr[2:0])
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  // CTRL bit positions
  localparam int CTRL_GO_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS bit positions
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

endpackage

// File: rtl/dma_csr_regfile_if.sv
// -----------------------------------------------------------------------------
// dma_csr_if
// Avalon-MM-style CSR bus between the host (master) and the DMA CSR slave.
//   csr_wr / csr_rd   : requests, held by the master until csr_wait_rq is low
//   csr_addr          : word address, [2:0] register, [6:3] channel
//   csr_wr_data       : write data
//   csr_wait_rq       : stall from the slave; a request completes when low
//   csr_rd_data       : read data, nonzero only in the read-valid cycle
// -----------------------------------------------------------------------------
interface dma_csr_if #(
  parameter int DATA_W = 32
);

  logic              csr_wr;
  logic              csr_rd;
  logic [31:0]       csr_addr;
  logic [DATA_W-1:0] csr_wr_data;
  logic              csr_wait_rq;
  logic [DATA_W-1:0] csr_rd_data;

  modport master (
    output csr_wr, csr_rd, csr_addr, csr_wr_data,
    input  csr_wait_rq, csr_rd_data
  );

  modport slave (
    input  csr_wr, csr_rd, csr_addr, csr_wr_data,
    output csr_wait_rq, csr_rd_data
  );

endinterface

// File: rtl/dma_csr_regfile_channel.sv
// -----------------------------------------------------------------------------
// dma_csr_channel
// Register bank of one DMA channel: SRC, DST, LEN, CTRL.IRQ_EN and the
// STATUS DONE/ERR flags, plus the GO pulse towards the channel engine.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_wrEn         : one-cycle write strobe for this channel
//   i_regSel       : register offset of the write
//   i_wrData       : write data
//   i_busy         : engine busy level
//   i_done         : engine completion pulse
//   o_src/o_dst    : address registers
//   o_len          : length register
//   o_irqEn        : CTRL.IRQ_EN
//   o_doneFlag     : STATUS.DONE
//   o_errFlag      : STATUS.ERR
//   o_go           : one-cycle start pulse, the cycle after the CTRL write
// -----------------------------------------------------------------------------
module dma_csr_channel
  import dma_csr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wrEn,
  input  logic [2:0]        i_regSel,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_busy,
  input  logic              i_done,
  output logic [DATA_W-1:0] o_src,
  output logic [DATA_W-1:0] o_dst,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_irqEn,
  output logic              o_doneFlag,
  output logic              o_errFlag,
  output logic              o_go
);

  logic [DATA_W-1:0] r_src;
  logic [DATA_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic              r_irqEn;
  logic              r_done;
  logic              r_err;
  logic              r_go;

  // Register writes. GO is refused (and ERR raised) when the engine is still
  // busy or no length has been programmed; r_go only ever lives one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_irqEn <= 1'b0;
      r_err   <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      r_go <= 1'b0;
      if (i_wrEn) begin
        case (i_regSel)
          REG_SRC: r_src <= i_wrData;
          REG_DST: r_dst <= i_wrData;
          REG_LEN: r_len <= i_wrData[LEN_W-1:0];
          REG_CTRL: begin
            r_irqEn <= i_wrData[CTRL_IRQ_EN_BIT];
            if (i_wrData[CTRL_GO_BIT]) begin
              if (!i_busy && (r_len != '0)) begin
                r_go <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          REG_STATUS: begin
            if (i_wrData[STAT_ERR_BIT]) begin
              r_err <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // DONE is set by the engine and cleared by software; when both happen on
  // the same edge the engine's set wins so a completion is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else if (i_done) begin
      r_done <= 1'b1;
    end else if (i_wrEn && (i_regSel == REG_STATUS) && i_wrData[STAT_DONE_BIT]) begin
      r_done <= 1'b0;
    end
  end

  assign o_src      = r_src;
  assign o_dst      = r_dst;
  assign o_len      = r_len;
  assign o_irqEn    = r_irqEn;
  assign o_doneFlag = r_done;
  assign o_errFlag  = r_err;
  assign o_go       = r_go;

endmodule

// File: rtl/dma_csr_regfile.sv
// -----------------------------------------------------------------------------
// dma_csr_regfile
// Multi-channel CSR slave for the DMA: bus FSM, address decode, read mux and
// NUM_CH instances of dma_csr_channel.
// Optional feature macro: DMA_CSR_IRQ_EN (adds the registered irq output).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   csr          : CSR bus (dma_csr_if.slave)
//   ch_go        : one-cycle start pulse per channel
//   ch_src       : flattened source addresses, channel i at [i*DATA_W +: DATA_W]
//   ch_dst       : flattened destination addresses
//   ch_len       : flattened lengths, channel i at [i*LEN_W +: LEN_W]
//   ch_busy      : engine busy levels
//   ch_done      : engine completion pulses
//   irq          : (DMA_CSR_IRQ_EN only) OR of DONE&IRQ_EN and ERR, registered
// -----------------------------------------------------------------------------
module dma_csr_regfile
  import dma_csr_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 24,
  parameter int RD_WAIT = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  dma_csr_if.slave                 csr,
  output logic [NUM_CH-1:0]        ch_go,
  output logic [NUM_CH*DATA_W-1:0] ch_src,
  output logic [NUM_CH*DATA_W-1:0] ch_dst,
  output logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH-1:0]        ch_busy,
  input  logic [NUM_CH-1:0]        ch_done
`ifdef DMA_CSR_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam logic [3:0] CNT_INIT = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

  csr_state_e        r_state;
  csr_state_e        w_nextState;
  logic [2:0]        r_regSel;
  logic [3:0]        r_chSel;
  logic [DATA_W-1:0] r_wrData;
  logic [3:0]        r_cnt;
  logic [NUM_CH-1:0] w_wrEn;
  logic [NUM_CH-1:0] w_irqEn;
  logic [NUM_CH-1:0] w_doneFlag;
  logic [NUM_CH-1:0] w_errFlag;
  logic [DATA_W-1:0] w_rdData;
  logic              w_unusedAddr;

  // Only the channel and register fields of the address are decoded
  assign w_unusedAddr = ^csr.csr_addr[31:7];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a simultaneous write and read takes the write path
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (csr.csr_wr) begin
          w_nextState = ST_WR_EN;
        end else if (csr.csr_rd) begin
          w_nextState = (RD_WAIT == 0) ? ST_RD_VALID : ST_RD_WAIT;
        end
      end
      ST_WR_EN:    w_nextState = ST_IDLE;
      ST_RD_WAIT:  if (r_cnt == 4'd0) w_nextState = ST_RD_VALID;
      ST_RD_VALID: w_nextState = ST_IDLE;
      default:     w_nextState = ST_IDLE;
    endcase
  end

  // Request capture in IDLE and the read wait-state counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_regSel <= '0;
      r_chSel  <= '0;
      r_wrData <= '0;
      r_cnt    <= '0;
    end else if ((r_state == ST_IDLE) && (csr.csr_wr || csr.csr_rd)) begin
      r_regSel <= csr.csr_addr[2:0];
      r_chSel  <= csr.csr_addr[6:3];
      r_wrData <= csr.csr_wr_data;
      r_cnt    <= CNT_INIT;
    end else if ((r_state == ST_RD_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // The master is released exactly in the WR_EN and RD_VALID cycles
  assign csr.csr_wait_rq = (csr.csr_wr | csr.csr_rd) &
                           (r_state != ST_WR_EN) & (r_state != ST_RD_VALID);

  // Per-channel write strobes; channels at or above NUM_CH never match
  always_comb begin
    w_wrEn = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wrEn[i] = (r_state == ST_WR_EN) && (r_chSel == 4'(i));
    end
  end

  // Read mux; drives zero outside RD_VALID and for absent channels
  always_comb begin
    w_rdData = '0;
    if (r_state == ST_RD_VALID) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_chSel == 4'(i)) begin
          case (r_regSel)
            REG_SRC:  w_rdData = ch_src[i*DATA_W +: DATA_W];
            REG_DST:  w_rdData = ch_dst[i*DATA_W +: DATA_W];
            REG_LEN:  w_rdData = DATA_W'(ch_len[i*LEN_W +: LEN_W]);
            REG_CTRL: w_rdData[CTRL_IRQ_EN_BIT] = w_irqEn[i];
            REG_STATUS: begin
              w_rdData[STAT_BUSY_BIT] = ch_busy[i];
              w_rdData[STAT_DONE_BIT] = w_doneFlag[i];
              w_rdData[STAT_ERR_BIT]  = w_errFlag[i];
            end
            default: w_rdData = '0;
          endcase
        end
      end
    end
  end

  assign csr.csr_rd_data = w_rdData;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_csr_channel #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_wrEn     (w_wrEn[g]),
      .i_regSel   (r_regSel),
      .i_wrData   (r_wrData),
      .i_busy     (ch_busy[g]),
      .i_done     (ch_done[g]),
      .o_src      (ch_src[g*DATA_W +: DATA_W]),
      .o_dst      (ch_dst[g*DATA_W +: DATA_W]),
      .o_len      (ch_len[g*LEN_W +: LEN_W]),
      .o_irqEn    (w_irqEn[g]),
      .o_doneFlag (w_doneFlag[g]),
      .o_errFlag  (w_errFlag[g]),
      .o_go       (ch_go[g])
    );
  end

`ifdef DMA_CSR_IRQ_EN
  logic r_irq;

  // Interrupt: any enabled DONE or any ERR, registered one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (|(w_doneFlag & w_irqEn)) | (|w_errFlag);
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_dma_csr_regfile.sv
// -----------------------------------------------------------------------------
// tb_dma_csr_regfile
// Self-checking bench for dma_csr_regfile: directed scenarios plus a random
// phase checked against a behavioural model of the register map.
// Optional feature macro: DMA_CSR_IRQ_EN (enables the irq scenario).
// -----------------------------------------------------------------------------
module tb_dma_csr_regfile;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 24;
  localparam int RD_WAIT = 2;
  localparam int MAX_WAIT = 40;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NUM_CH-1:0]        chGo;
  logic [NUM_CH*DATA_W-1:0] chSrc;
  logic [NUM_CH*DATA_W-1:0] chDst;
  logic [NUM_CH*LEN_W-1:0]  chLen;
  logic [NUM_CH-1:0]        chBusy = '0;
  logic [NUM_CH-1:0]        chDone = '0;
`ifdef DMA_CSR_IRQ_EN
  logic                     irq;
`endif

  int compared = 0;
  int mismatched = 0;

  // Behavioural register-map model, sized for every addressable channel
  logic [31:0] mSrc [16];
  logic [31:0] mDst [16];
  logic [31:0] mLen [16];
  logic        mIrqEn [16];
  logic        mDone [16];
  logic        mErr [16];

  always #5 clk = ~clk;

  dma_csr_if #(.DATA_W(DATA_W)) csrIf ();

  dma_csr_regfile #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .RD_WAIT (RD_WAIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .csr     (csrIf.slave),
    .ch_go   (chGo),
    .ch_src  (chSrc),
    .ch_dst  (chDst),
    .ch_len  (chLen),
    .ch_busy (chBusy),
    .ch_done (chDone)
`ifdef DMA_CSR_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) begin
      mSrc[i] = '0; mDst[i] = '0; mLen[i] = '0;
      mIrqEn[i] = 1'b0; mDone[i] = 1'b0; mErr[i] = 1'b0;
    end
  endfunction

  // Applies a write to the model and returns the GO pulses it should cause
  function automatic logic [NUM_CH-1:0] modelWrite(int ch, int rg, logic [31:0] data,
                                                   logic [NUM_CH-1:0] busy);
    logic [NUM_CH-1:0] go;
    go = '0;
    if (ch < NUM_CH) begin
      case (rg)
        0: mSrc[ch] = data;
        1: mDst[ch] = data;
        2: mLen[ch] = data & ((32'd1 << LEN_W) - 32'd1);
        3: begin
          mIrqEn[ch] = data[1];
          if (data[0]) begin
            if (!busy[ch] && (mLen[ch] != 0)) go[ch] = 1'b1;
            else mErr[ch] = 1'b1;
          end
        end
        4: begin
          if (data[1]) mDone[ch] = 1'b0;
          if (data[2]) mErr[ch] = 1'b0;
        end
        default: ;
      endcase
    end
    return go;
  endfunction

  function automatic logic [31:0] modelRead(int ch, int rg, logic [NUM_CH-1:0] busy);
    if (ch >= NUM_CH) return 32'd0;
    case (rg)
      0: return mSrc[ch];
      1: return mDst[ch];
      2: return mLen[ch];
      3: return {30'd0, mIrqEn[ch], 1'b0};
      4: return {29'd0, mErr[ch], mDone[ch], busy[ch]};
      default: return 32'd0;
    endcase
  endfunction

  // Word address with random don't-care upper bits
  function automatic logic [31:0] addrOf(int ch, int rg);
    logic [31:0] upper;
    upper = $urandom;
    return (upper & 32'hFFFF_FF80) | 32'(ch * 8 + rg);
  endfunction

  // Drives one bus request until csr_wait_rq drops; reports the stall count
  // (MAX_WAIT on timeout) and csr_rd_data in the completing cycle
  task automatic applyStimulus(input logic doWr, input logic doRd, input logic [31:0] addr,
                               input logic [31:0] data, output int waits,
                               output logic [31:0] rdData);
    @(negedge clk);
    csrIf.csr_wr = doWr;
    csrIf.csr_rd = doRd;
    csrIf.csr_addr = addr;
    csrIf.csr_wr_data = data;
    waits = 0;
    #1;
    while ((csrIf.csr_wait_rq !== 1'b0) && (waits < MAX_WAIT)) begin
      waits++;
      @(negedge clk);
      #1;
    end
    rdData = csrIf.csr_rd_data;
    @(posedge clk);
    #1;
    csrIf.csr_wr = 1'b0;
    csrIf.csr_rd = 1'b0;
    csrIf.csr_addr = '0;
    csrIf.csr_wr_data = '0;
  endtask

  task automatic test_reset();
    int w;
    logic [31:0] d;
    applyStimulus(1'b1, 1'b0, addrOf(0, 0), 32'h1234_5678, w, d);
    applyStimulus(1'b1, 1'b0, addrOf(1, 1), 32'h0BAD_F00D, w, d);
    applyStimulus(1'b1, 1'b0, addrOf(2, 2), 32'h0000_0040, w, d);
    // start a read and pull reset while it is still stalled
    @(negedge clk);
    csrIf.csr_rd = 1'b1;
    csrIf.csr_addr = addrOf(0, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    csrIf.csr_rd = 1'b0;
    #1;
    compared++; if (csrIf.csr_wait_rq !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_wait_rq: got %b expected 0", csrIf.csr_wait_rq); end
    compared++; if (csrIf.csr_rd_data !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_rd_data: got %h expected 0", csrIf.csr_rd_data); end
    compared++; if (chGo !== '0) begin mismatched++; $display("[TB] FAIL rst_ch_go: got %b expected 0", chGo); end
    compared++; if (chSrc !== '0) begin mismatched++; $display("[TB] FAIL rst_ch_src: got %h expected 0", chSrc); end
    compared++; if (chDst !== '0) begin mismatched++; $display("[TB] FAIL rst_ch_dst: got %h expected 0", chDst); end
    compared++; if (chLen !== '0) begin mismatched++; $display("[TB] FAIL rst_ch_len: got %h expected 0", chLen); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    applyStimulus(1'b0, 1'b1, addrOf(0, 0), 32'd0, w, d);
    compared++; if (d !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_read_src: got %h expected 0", d); end
    compared++; if (w !== RD_WAIT + 1) begin mismatched++; $display("[TB] FAIL rst_read_wait: got %0d expected %0d", w, RD_WAIT + 1); end
  endtask

  task automatic test_write_readback();
    int w;
    logic [31:0] d;
    logic [NUM_CH-1:0] go;
    go = modelWrite(2, 0, 32'hDEAD_BEEF, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(2, 0), 32'hDEAD_BEEF, w, d);
    compared++; if (w !== 1) begin mismatched++; $display("[TB] FAIL wr_wait: got %0d expected 1", w); end
    compared++; if (chSrc[2*DATA_W +: DATA_W] !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL wr_ch_src2: got %h expected deadbeef", chSrc[2*DATA_W +: DATA_W]); end
    applyStimulus(1'b0, 1'b1, addrOf(2, 0), 32'd0, w, d);
    compared++; if (w !== RD_WAIT + 1) begin mismatched++; $display("[TB] FAIL rd_wait: got %0d expected %0d", w, RD_WAIT + 1); end
    compared++; if (d !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL rd_data: got %h expected deadbeef", d); end
    compared++; if (go !== '0) begin mismatched++; $display("[TB] FAIL wr_model_go: got %b expected 0", go); end
  endtask

  task automatic test_go();
    int w;
    logic [31:0] d;
    logic [NUM_CH-1:0] go;
    go = modelWrite(1, 2, 32'h0000_0100, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(1, 2), 32'h0000_0100, w, d);
    compared++; if (chLen[1*LEN_W +: LEN_W] !== 24'h000100) begin mismatched++; $display("[TB] FAIL go_len1: got %h expected 000100", chLen[1*LEN_W +: LEN_W]); end
    go = modelWrite(1, 3, 32'h1, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(1, 3), 32'h1, w, d);
    @(negedge clk);
    compared++; if (chGo !== 4'b0010) begin mismatched++; $display("[TB] FAIL go_pulse: got %b expected 0010", chGo); end
    @(negedge clk);
    compared++; if (chGo !== 4'b0000) begin mismatched++; $display("[TB] FAIL go_pulse_width: got %b expected 0000", chGo); end
    // engine still busy: no pulse, ERR raised
    chBusy[1] = 1'b1;
    go = modelWrite(1, 3, 32'h1, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(1, 3), 32'h1, w, d);
    @(negedge clk);
    compared++; if (chGo !== 4'b0000) begin mismatched++; $display("[TB] FAIL go_busy_pulse: got %b expected 0000", chGo); end
    applyStimulus(1'b0, 1'b1, addrOf(1, 4), 32'd0, w, d);
    compared++; if (d !== 32'h5) begin mismatched++; $display("[TB] FAIL go_busy_status: got %h expected 5", d); end
    chBusy[1] = 1'b0;
    // zero length: no pulse, ERR raised on channel 0
    go = modelWrite(0, 3, 32'h1, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(0, 3), 32'h1, w, d);
    @(negedge clk);
    compared++; if (chGo !== 4'b0000) begin mismatched++; $display("[TB] FAIL go_len0_pulse: got %b expected 0000", chGo); end
    applyStimulus(1'b0, 1'b1, addrOf(0, 4), 32'd0, w, d);
    compared++; if (d !== 32'h4) begin mismatched++; $display("[TB] FAIL go_len0_status: got %h expected 4", d); end
    // W1C of ERR
    go = modelWrite(1, 4, 32'h4, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(1, 4), 32'h4, w, d);
    applyStimulus(1'b0, 1'b1, addrOf(1, 4), 32'd0, w, d);
    compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL go_err_clear: got %h expected 0", d); end
  endtask

  task automatic test_done_race();
    int w;
    logic [31:0] d;
    logic [NUM_CH-1:0] go;
    @(negedge clk);
    chDone[3] = 1'b1;
    @(posedge clk);
    #1;
    chDone[3] = 1'b0;
    mDone[3] = 1'b1;
    applyStimulus(1'b0, 1'b1, addrOf(3, 4), 32'd0, w, d);
    compared++; if (d !== 32'h2) begin mismatched++; $display("[TB] FAIL done_set: got %h expected 2", d); end
    // completion and W1C land on the same edge
    fork
      applyStimulus(1'b1, 1'b0, addrOf(3, 4), 32'h2, w, d);
      begin
        @(negedge clk);
        @(negedge clk);
        chDone[3] = 1'b1;
        @(posedge clk);
        #1;
        chDone[3] = 1'b0;
      end
    join
    applyStimulus(1'b0, 1'b1, addrOf(3, 4), 32'd0, w, d);
    compared++; if (d !== 32'h2) begin mismatched++; $display("[TB] FAIL done_race: got %h expected 2", d); end
    go = modelWrite(3, 4, 32'h2, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(3, 4), 32'h2, w, d);
    applyStimulus(1'b0, 1'b1, addrOf(3, 4), 32'd0, w, d);
    compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL done_clear: got %h expected 0", d); end
  endtask

  task automatic test_edge_cases();
    int w;
    logic [31:0] d;
    logic [NUM_CH-1:0] go;
    // write and read together: only the write happens
    go = modelWrite(0, 1, 32'hA5A5_0001, chBusy);
    applyStimulus(1'b1, 1'b1, addrOf(0, 1), 32'hA5A5_0001, w, d);
    compared++; if (w !== 1) begin mismatched++; $display("[TB] FAIL wrrd_wait: got %0d expected 1", w); end
    compared++; if (d !== 32'd0) begin mismatched++; $display("[TB] FAIL wrrd_rd_data: got %h expected 0", d); end
    applyStimulus(1'b0, 1'b1, addrOf(0, 1), 32'd0, w, d);
    compared++; if (d !== 32'hA5A5_0001) begin mismatched++; $display("[TB] FAIL wrrd_readback: got %h expected a5a50001", d); end
    // absent channel
    go = modelWrite(5, 0, 32'hFFFF_FFFF, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(5, 0), 32'hFFFF_FFFF, w, d);
    compared++; if (w !== 1) begin mismatched++; $display("[TB] FAIL ch5_wr_wait: got %0d expected 1", w); end
    for (int i = 0; i < NUM_CH; i++) begin
      compared++; if (chSrc[i*DATA_W +: DATA_W] !== mSrc[i]) begin mismatched++; $display("[TB] FAIL ch5_no_effect ch%0d: got %h expected %h", i, chSrc[i*DATA_W +: DATA_W], mSrc[i]); end
    end
    applyStimulus(1'b0, 1'b1, addrOf(5, 0), 32'd0, w, d);
    compared++; if (d !== 32'd0) begin mismatched++; $display("[TB] FAIL ch5_read: got %h expected 0", d); end
    compared++; if (w !== RD_WAIT + 1) begin mismatched++; $display("[TB] FAIL ch5_rd_wait: got %0d expected %0d", w, RD_WAIT + 1); end
    // reserved offset and LEN truncation
    applyStimulus(1'b1, 1'b0, addrOf(0, 6), 32'hFFFF_FFFF, w, d);
    applyStimulus(1'b0, 1'b1, addrOf(0, 6), 32'd0, w, d);
    compared++; if (d !== 32'd0) begin mismatched++; $display("[TB] FAIL reserved_read: got %h expected 0", d); end
    go = modelWrite(2, 2, 32'hFFFF_FFFF, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(2, 2), 32'hFFFF_FFFF, w, d);
    applyStimulus(1'b0, 1'b1, addrOf(2, 2), 32'd0, w, d);
    compared++; if (d !== 32'h00FF_FFFF) begin mismatched++; $display("[TB] FAIL len_trunc: got %h expected 00ffffff", d); end
  endtask

  task automatic test_random();
    int w, ch, rg;
    logic [31:0] d, data, exp;
    logic [NUM_CH-1:0] expGo;
    for (int k = 0; k < 80; k++) begin
      ch = $urandom_range(0, 5);
      rg = $urandom_range(0, 7);
      data = $urandom;
      if ($urandom_range(0, 4) == 0) data = data & 32'hFF00_0007;
      chBusy = NUM_CH'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        expGo = modelWrite(ch, rg, data, chBusy);
        applyStimulus(1'b1, 1'b0, addrOf(ch, rg), data, w, d);
        compared++; if (w !== 1) begin mismatched++; $display("[TB] FAIL rnd_wr_wait op%0d: got %0d expected 1", k, w); end
        @(negedge clk);
        compared++; if (chGo !== expGo) begin mismatched++; $display("[TB] FAIL rnd_go op%0d ch%0d: got %b expected %b", k, ch, chGo, expGo); end
      end else begin
        exp = modelRead(ch, rg, chBusy);
        applyStimulus(1'b0, 1'b1, addrOf(ch, rg), 32'd0, w, d);
        compared++; if (w !== RD_WAIT + 1) begin mismatched++; $display("[TB] FAIL rnd_rd_wait op%0d: got %0d expected %0d", k, w, RD_WAIT + 1); end
        compared++; if (d !== exp) begin mismatched++; $display("[TB] FAIL rnd_rd_data op%0d ch%0d reg%0d: got %h expected %h", k, ch, rg, d, exp); end
      end
    end
    chBusy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      compared++; if (chSrc[i*DATA_W +: DATA_W] !== mSrc[i]) begin mismatched++; $display("[TB] FAIL rnd_ch_src ch%0d: got %h expected %h", i, chSrc[i*DATA_W +: DATA_W], mSrc[i]); end
      compared++; if (chDst[i*DATA_W +: DATA_W] !== mDst[i]) begin mismatched++; $display("[TB] FAIL rnd_ch_dst ch%0d: got %h expected %h", i, chDst[i*DATA_W +: DATA_W], mDst[i]); end
      compared++; if (32'(chLen[i*LEN_W +: LEN_W]) !== mLen[i]) begin mismatched++; $display("[TB] FAIL rnd_ch_len ch%0d: got %h expected %h", i, chLen[i*LEN_W +: LEN_W], mLen[i]); end
    end
  endtask

`ifdef DMA_CSR_IRQ_EN
  task automatic test_irq();
    int w;
    logic [31:0] d;
    logic [NUM_CH-1:0] go;
    for (int i = 0; i < NUM_CH; i++) begin
      go = modelWrite(i, 4, 32'h6, chBusy);
      applyStimulus(1'b1, 1'b0, addrOf(i, 4), 32'h6, w, d);
      go = modelWrite(i, 3, 32'h0, chBusy);
      applyStimulus(1'b1, 1'b0, addrOf(i, 3), 32'h0, w, d);
    end
    go = modelWrite(0, 3, 32'h2, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(0, 3), 32'h2, w, d);
    @(negedge clk);
    compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_idle: got %b expected 0", irq); end
    chDone[0] = 1'b1;
    @(posedge clk);
    #1;
    chDone[0] = 1'b0;
    mDone[0] = 1'b1;
    @(posedge clk);
    #1;
    compared++; if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_set: got %b expected 1", irq); end
    go = modelWrite(0, 4, 32'h2, chBusy);
    applyStimulus(1'b1, 1'b0, addrOf(0, 4), 32'h2, w, d);
    compared++; if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_hold: got %b expected 1", irq); end
    @(posedge clk);
    #1;
    compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_clear: got %b expected 0", irq); end
  endtask
`endif

  initial begin
    csrIf.csr_wr = 1'b0;
    csrIf.csr_rd = 1'b0;
    csrIf.csr_addr = '0;
    csrIf.csr_wr_data = '0;
    modelReset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] starting dma_csr_regfile bench");
    test_reset();
    test_write_readback();
    test_go();
    test_done_race();
    test_edge_cases();
    test_random();
`ifdef DMA_CSR_IRQ_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
